// File: rtl/key_event_arbiter.sv
// key_event_arbiter: collects one-cycle key_flag pulses into per-key pending
// latches and serialises them round-robin onto a valid/ready event stream,
// with sticky per-key overflow status and a saturating drop counter.
module key_event_arbiter #(
   parameter int unsigned KEY_NUM = 4,
   parameter int unsigned IDX_W   = 2,
   parameter int unsigned DROP_W  = 8
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   input  logic [KEY_NUM-1:0] key_flag,
   input  logic               evt_ready,
   input  logic               clr_stat,
   output logic               evt_valid,
   output logic [IDX_W-1:0]   evt_code,
   output logic [KEY_NUM-1:0] pend,
   output logic [KEY_NUM-1:0] overflow,
   output logic [DROP_W-1:0]  drop_cnt
);

   typedef enum logic {IDLE, VALID} state_t;

   localparam int unsigned SUM_W = DROP_W + 5;

   state_t               state, state_nxt;
   logic [IDX_W-1:0]     rr_ptr;
   logic                 slot_free;
   logic                 grant_vld;
   logic [IDX_W-1:0]     grant_idx;
   logic [KEY_NUM-1:0]   grant_oh;
   logic [KEY_NUM-1:0]   drop;
   logic [KEY_NUM-1:0]   pend_nxt;
   logic [SUM_W-1:0]     cnt_sum;
   logic [DROP_W-1:0]    cnt_nxt;

   assign evt_valid = (state == VALID);
   assign slot_free = (state == IDLE) | (evt_valid & evt_ready);

   // Round-robin search over registered pend, starting at rr_ptr and wrapping.
   always_comb begin
      logic [IDX_W:0] cand;
      grant_vld = 1'b0;
      grant_idx = '0;
      grant_oh  = '0;
      for (int unsigned k = 0; k < KEY_NUM; k++) begin
         cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
         if (cand >= (IDX_W+1)'(KEY_NUM))
            cand = cand - (IDX_W+1)'(KEY_NUM);
         if (!grant_vld && pend[cand[IDX_W-1:0]]) begin
            grant_vld = slot_free;
            grant_idx = cand[IDX_W-1:0];
         end
      end
      if (grant_vld)
         grant_oh[grant_idx] = 1'b1;
   end

   // Pending latch update, drop detection and saturating counter arithmetic.
   always_comb begin
      drop     = key_flag & pend & ~grant_oh;
      pend_nxt = key_flag | (pend & ~grant_oh);
      cnt_sum  = clr_stat ? '0 : SUM_W'(drop_cnt);
      for (int unsigned i = 0; i < KEY_NUM; i++)
         cnt_sum = cnt_sum + SUM_W'(drop[i]);
      if (cnt_sum > SUM_W'({DROP_W{1'b1}}))
         cnt_nxt = '1;
      else
         cnt_nxt = cnt_sum[DROP_W-1:0];
   end

   // Output handshake FSM: next-state selection.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_vld) state_nxt = VALID;
         VALID:   if (evt_ready) state_nxt = grant_vld ? VALID : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State, event register, pointer, pending and status registers.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state    <= IDLE;
         evt_code <= '0;
         rr_ptr   <= '0;
         pend     <= '0;
         overflow <= '0;
         drop_cnt <= '0;
      end else begin
         state <= state_nxt;
         pend  <= pend_nxt;
         if (grant_vld) begin
            evt_code <= grant_idx;
            rr_ptr   <= (grant_idx == IDX_W'(KEY_NUM-1)) ? '0 : grant_idx + 1'b1;
         end
         // A drop in the same cycle as clr_stat survives the clear.
         overflow <= (clr_stat ? '0 : overflow) | drop;
         drop_cnt <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_key_event_arbiter.sv
// Directed self-checking bench for key_event_arbiter (KEY_NUM=4).
module tb_key_event_arbiter;

   localparam int unsigned KEY_NUM = 4;
   localparam int unsigned IDX_W   = 2;
   localparam int unsigned DROP_W  = 8;

   logic               sys_clk = 1'b0;
   logic               sys_rst_n;
   logic [KEY_NUM-1:0] key_flag;
   logic               evt_ready;
   logic               clr_stat;
   logic               evt_valid;
   logic [IDX_W-1:0]   evt_code;
   logic [KEY_NUM-1:0] pend;
   logic [KEY_NUM-1:0] overflow;
   logic [DROP_W-1:0]  drop_cnt;

   int checks = 0;
   int errors = 0;

   key_event_arbiter #(.KEY_NUM(KEY_NUM), .IDX_W(IDX_W), .DROP_W(DROP_W)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .key_flag  (key_flag),
      .evt_ready (evt_ready),
      .clr_stat  (clr_stat),
      .evt_valid (evt_valid),
      .evt_code  (evt_code),
      .pend      (pend),
      .overflow  (overflow),
      .drop_cnt  (drop_cnt)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One rising edge, then land on the falling edge for sampling/driving.
   task automatic step();
      @(posedge sys_clk);
      @(negedge sys_clk);
   endtask

   initial begin
      sys_rst_n = 1'b0;
      key_flag  = '0;
      evt_ready = 1'b0;
      clr_stat  = 1'b0;
      step();
      step();
      check("rst_valid", evt_valid, 0);
      check("rst_code", evt_code, 0);
      check("rst_pend", pend, 0);
      check("rst_ovf", overflow, 0);
      check("rst_drop", drop_cnt, 0);
      sys_rst_n = 1'b1;
      evt_ready = 1'b1;

      // T1 single press, two-cycle latency
      key_flag = 4'b0100; step(); key_flag = '0;
      check("t1_pend", pend, 4'b0100);
      check("t1_lat", evt_valid, 0);
      step();
      check("t1_valid", evt_valid, 1);
      check("t1_code", evt_code, 2);
      check("t1_pend0", pend, 0);
      step();
      check("t1_idle", evt_valid, 0);

      // bring rr_ptr back to 0 via key 3
      key_flag = 4'b1000; step(); key_flag = '0; step();
      check("al_code", evt_code, 3);
      step();
      check("al_idle", evt_valid, 0);

      // T2 simultaneous presses, back-to-back issue
      key_flag = 4'b1111; step(); key_flag = '0;
      check("t2_pend", pend, 4'b1111);
      for (int i = 0; i < 4; i++) begin
         step();
         check("t2_valid", evt_valid, 1);
         check("t2_code", evt_code, i);
      end
      step();
      check("t2_idle", evt_valid, 0);
      check("t2_pend0", pend, 0);

      // T3 fairness: rr_ptr=2 via key 1
      key_flag = 4'b0010; step(); key_flag = '0; step();
      check("t3_pre", evt_code, 1);
      step();
      key_flag = 4'b0011; step(); key_flag = '0;
      check("t3_pend", pend, 4'b0011);
      step(); check("t3_c0", evt_code, 0);
      step(); check("t3_c1", evt_code, 1);
      step(); check("t3_idle", evt_valid, 0);
      key_flag = 4'b1010; step(); key_flag = '0; step();
      check("t3_c3", evt_code, 3);
      step(); check("t3_c1b", evt_code, 1);
      step(); check("t3_idle2", evt_valid, 0);

      // T4 backpressure and overflow
      evt_ready = 1'b0;
      key_flag = 4'b0010; step(); key_flag = '0; step();
      check("t4_valid", evt_valid, 1);
      check("t4_code", evt_code, 1);
      check("t4_pend0", pend, 0);
      key_flag = 4'b0010; step();
      check("t4_rep1_pend", pend, 4'b0010);
      check("t4_rep1_ovf", overflow, 0);
      check("t4_rep1_drop", drop_cnt, 0);
      check("t4_rep1_code", evt_code, 1);
      step(); key_flag = '0;
      check("t4_rep2_ovf", overflow, 4'b0010);
      check("t4_rep2_drop", drop_cnt, 1);
      check("t4_rep2_pend", pend, 4'b0010);
      check("t4_rep2_code", evt_code, 1);
      step();
      check("t4_hold_code", evt_code, 1);
      check("t4_hold_valid", evt_valid, 1);
      evt_ready = 1'b1; step();
      check("t4_next_valid", evt_valid, 1);
      check("t4_next_code", evt_code, 1);
      check("t4_next_pend", pend, 0);
      step();
      check("t4_idle", evt_valid, 0);

      // T5 saturation and clear
      clr_stat = 1'b1; step(); clr_stat = 1'b0;
      check("t5_clr_ovf", overflow, 0);
      check("t5_clr_drop", drop_cnt, 0);
      evt_ready = 1'b0;
      key_flag = 4'b0001; step(); key_flag = '0; step();
      check("t5_valid", evt_valid, 1);
      check("t5_code", evt_code, 0);
      key_flag = 4'b0001;
      for (int n = 0; n < 255; n++) step();
      check("t5_cnt254", drop_cnt, 254);
      step();
      check("t5_cnt255", drop_cnt, 255);
      for (int n = 0; n < 5; n++) step();
      check("t5_sat", drop_cnt, 255);
      check("t5_ovf", overflow, 4'b0001);
      check("t5_code_hold", evt_code, 0);
      clr_stat = 1'b1; step(); clr_stat = 1'b0;
      check("t5_clrdrop_ovf", overflow, 4'b0001);
      check("t5_clrdrop_cnt", drop_cnt, 1);
      key_flag = '0;
      clr_stat = 1'b1; step(); clr_stat = 1'b0;
      check("t5_clr2_ovf", overflow, 0);
      check("t5_clr2_cnt", drop_cnt, 0);
      evt_ready = 1'b1; step(); step();
      check("t5_drain", evt_valid, 0);

      // T6 reset mid-operation
      evt_ready = 1'b0;
      key_flag = 4'b0100; step(); key_flag = '0; step();
      check("t6_code", evt_code, 2);
      key_flag = 4'b1010; step(); key_flag = '0;
      check("t6_pend", pend, 4'b1010);
      check("t6_valid", evt_valid, 1);
      #1 sys_rst_n = 1'b0;
      #1;
      check("t6_async_valid", evt_valid, 0);
      check("t6_async_code", evt_code, 0);
      check("t6_async_pend", pend, 0);
      check("t6_async_ovf", overflow, 0);
      step();
      sys_rst_n = 1'b1;
      evt_ready = 1'b1;
      step(); step();
      check("t6_no_stale", evt_valid, 0);
      check("t6_pend0", pend, 0);
      key_flag = 4'b1010; step(); key_flag = '0; step();
      check("t6_rr_c1", evt_code, 1);
      step();
      check("t6_rr_c3", evt_code, 3);
      step();
      check("t6_idle", evt_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
